// File: rtl/model_matrix_fixed_divider_sequencer.sv
// Row-by-row sequencer that feeds an I x J element-wise division through one shared
// vector divider and forwards its quotients downstream with row/element strobes.
module model_matrix_fixed_divider_sequencer #(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   input  logic [DATA_SIZE-1:0] SIZE_I_IN,
   input  logic [DATA_SIZE-1:0] SIZE_J_IN,
   output logic                 DATA_IN_REQUEST,
   input  logic                 DATA_IN_ENABLE,
   input  logic [DATA_SIZE-1:0] DATA_A_IN,
   input  logic [DATA_SIZE-1:0] DATA_B_IN,
   output logic                 DATA_OUT_I_ENABLE,
   output logic                 DATA_OUT_J_ENABLE,
   output logic [DATA_SIZE-1:0] DATA_OUT,
   output logic                 VECTOR_START,
   input  logic                 VECTOR_READY,
   output logic                 VECTOR_DATA_A_IN_ENABLE,
   output logic                 VECTOR_DATA_B_IN_ENABLE,
   input  logic                 VECTOR_DATA_OUT_ENABLE,
   output logic [DATA_SIZE-1:0] VECTOR_SIZE_IN,
   output logic [DATA_SIZE-1:0] VECTOR_DATA_A_IN,
   output logic [DATA_SIZE-1:0] VECTOR_DATA_B_IN,
   input  logic [DATA_SIZE-1:0] VECTOR_DATA_OUT
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROW_START,
      S_FEED,
      S_WAIT,
      S_ENDER
   } state_t;

   localparam logic [CONTROL_SIZE-1:0] CTL_ONE = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};

   // Sizes are unsigned; zero-extend or truncate them to the counter width.
   function automatic logic [CONTROL_SIZE-1:0] to_control(input logic [DATA_SIZE-1:0] value);
      logic [CONTROL_SIZE-1:0] result;
      result = '0;
      for (int k = 0; k < CONTROL_SIZE && k < DATA_SIZE; k++) begin
         result[k] = value[k];
      end
      return result;
   endfunction

   state_t                  state;
   logic [CONTROL_SIZE-1:0] size_i;
   logic [CONTROL_SIZE-1:0] size_j;
   logic [CONTROL_SIZE-1:0] index_i;
   logic [CONTROL_SIZE-1:0] index_j;
   logic [CONTROL_SIZE-1:0] out_j;
   logic [CONTROL_SIZE-1:0] size_i_in;
   logic [CONTROL_SIZE-1:0] size_j_in;
   logic [CONTROL_SIZE-1:0] last_i;
   logic [CONTROL_SIZE-1:0] last_j;
   logic                    start_accept;
   logic                    zero_size;

   assign size_i_in    = to_control(SIZE_I_IN);
   assign size_j_in    = to_control(SIZE_J_IN);
   assign last_i       = size_i - CTL_ONE;
   assign last_j       = size_j - CTL_ONE;
   assign start_accept = (state == S_IDLE) && START;
   assign zero_size    = (size_i_in == '0) || (size_j_in == '0);

   // Every output is registered and set on the transition into the state that owns it,
   // so each strobe lands exactly one cycle after the event that caused it.
   always_ff @(posedge CLK) begin
      // NOTE: state registers take <= so every process sees pre-edge values; = here would race.
      if (RST) begin
         state                   <= S_IDLE;
         size_i                  <= '0;
         size_j                  <= '0;
         index_i                 <= '0;
         index_j                 <= '0;
         READY                   <= 1'b0;
         DATA_IN_REQUEST         <= 1'b0;
         VECTOR_START            <= 1'b0;
         VECTOR_SIZE_IN          <= '0;
         VECTOR_DATA_A_IN_ENABLE <= 1'b0;
         VECTOR_DATA_B_IN_ENABLE <= 1'b0;
         VECTOR_DATA_A_IN        <= '0;
         VECTOR_DATA_B_IN        <= '0;
      end else begin
         // NOTE: pulse outputs default low each cycle; only the branch that fires raises them.
         READY                   <= 1'b0;
         VECTOR_START            <= 1'b0;
         VECTOR_DATA_A_IN_ENABLE <= 1'b0;
         VECTOR_DATA_B_IN_ENABLE <= 1'b0;

         case (state)
            S_IDLE: begin
               if (START) begin
                  size_i         <= size_i_in;
                  size_j         <= size_j_in;
                  VECTOR_SIZE_IN <= SIZE_J_IN;
                  index_i        <= '0;
                  if (zero_size) begin
                     state <= S_ENDER;
                     READY <= 1'b1;
                  end else begin
                     state        <= S_ROW_START;
                     VECTOR_START <= 1'b1;
                  end
               end
            end

            S_ROW_START: begin
               index_j         <= '0;
               DATA_IN_REQUEST <= 1'b1;
               state           <= S_FEED;
            end

            S_FEED: begin
               if (DATA_IN_ENABLE) begin
                  VECTOR_DATA_A_IN        <= DATA_A_IN;
                  VECTOR_DATA_B_IN        <= DATA_B_IN;
                  VECTOR_DATA_A_IN_ENABLE <= 1'b1;
                  VECTOR_DATA_B_IN_ENABLE <= 1'b1;
                  if (index_j == last_j) begin
                     DATA_IN_REQUEST <= 1'b0;
                     state           <= S_WAIT;
                  end else begin
                     index_j <= index_j + CTL_ONE;
                  end
               end
            end

            S_WAIT: begin
               if (VECTOR_READY) begin
                  if (index_i == last_i) begin
                     state <= S_ENDER;
                     READY <= 1'b1;
                  end else begin
                     index_i      <= index_i + CTL_ONE;
                     state        <= S_ROW_START;
                     VECTOR_START <= 1'b1;
                  end
               end
            end

            S_ENDER: state <= S_IDLE;

            default: state <= S_IDLE;
         endcase
      end
   end

   // Result forwarding follows the divider alone, whatever the FSM is doing.
   always_ff @(posedge CLK) begin
      if (RST) begin
         DATA_OUT          <= '0;
         DATA_OUT_I_ENABLE <= 1'b0;
         DATA_OUT_J_ENABLE <= 1'b0;
         out_j             <= '0;
      end else begin
         DATA_OUT_J_ENABLE <= VECTOR_DATA_OUT_ENABLE;
         DATA_OUT_I_ENABLE <= VECTOR_DATA_OUT_ENABLE && (out_j == '0);
         if (VECTOR_DATA_OUT_ENABLE) begin
            DATA_OUT <= VECTOR_DATA_OUT;
            out_j    <= (out_j == last_j) ? '0 : out_j + CTL_ONE;
         end
         if (start_accept) begin
            out_j <= '0;
         end
      end
   end

endmodule

// File: tb/tb_model_matrix_fixed_divider_sequencer.sv
// Randomised bench: a divider stub returning A/B, a producer, and a per-cycle compare
// of every DUT output against matrix-level expectations (row-major quotient stream).
module tb_model_matrix_fixed_divider_sequencer;

   logic        CLK = 1'b0;
   logic        RST, START, READY;
   logic [63:0] SIZE_I_IN, SIZE_J_IN;
   logic        DATA_IN_REQUEST, DATA_IN_ENABLE;
   logic [63:0] DATA_A_IN, DATA_B_IN;
   logic        DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE;
   logic [63:0] DATA_OUT;
   logic        VECTOR_START, VECTOR_READY;
   logic        VECTOR_DATA_A_IN_ENABLE, VECTOR_DATA_B_IN_ENABLE, VECTOR_DATA_OUT_ENABLE;
   logic [63:0] VECTOR_SIZE_IN, VECTOR_DATA_A_IN, VECTOR_DATA_B_IN, VECTOR_DATA_OUT;

   always #5 CLK = ~CLK;

   model_matrix_fixed_divider_sequencer #(.DATA_SIZE(64), .CONTROL_SIZE(64)) dut (
      .CLK(CLK), .RST(RST), .START(START), .READY(READY),
      .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN),
      .DATA_IN_REQUEST(DATA_IN_REQUEST), .DATA_IN_ENABLE(DATA_IN_ENABLE),
      .DATA_A_IN(DATA_A_IN), .DATA_B_IN(DATA_B_IN),
      .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE), .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
      .DATA_OUT(DATA_OUT), .VECTOR_START(VECTOR_START), .VECTOR_READY(VECTOR_READY),
      .VECTOR_DATA_A_IN_ENABLE(VECTOR_DATA_A_IN_ENABLE),
      .VECTOR_DATA_B_IN_ENABLE(VECTOR_DATA_B_IN_ENABLE),
      .VECTOR_DATA_OUT_ENABLE(VECTOR_DATA_OUT_ENABLE), .VECTOR_SIZE_IN(VECTOR_SIZE_IN),
      .VECTOR_DATA_A_IN(VECTOR_DATA_A_IN), .VECTOR_DATA_B_IN(VECTOR_DATA_B_IN),
      .VECTOR_DATA_OUT(VECTOR_DATA_OUT)
   );

   typedef struct packed {
      logic [63:0] val;
      logic        first;
   } exp_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Stimulus controls set by the test sequence
   logic        rst_req = 1'b0, start_req = 1'b0, force_vready = 1'b0, junk_en = 1'b0;
   logic [63:0] si_drv = '0, sj_drv = '0;
   int          mode = 0;
   int          job_j = 0, prod_idx = 0, total = 0;
   logic [63:0] a_mem[64];
   logic [63:0] b_mem[64];

   // Reference model: expected quotient stream, and what the DUT actually emitted
   exp_t        exp_q[$];
   logic [63:0] obs_q[$];
   logic        obs_first[$];

   // Divider stub state
   logic [63:0] stub_q[$];
   logic [63:0] stub_size = '0;
   int          stub_cnt = 0, stub_cd = 0;

   // Compare-process history and per-job counters
   logic        mon_en = 1'b0;
   logic        p_rst = 1'b0, p_accept = 1'b0, p_vout_en = 1'b0;
   logic [63:0] p_a = '0, p_b = '0, p_vout = '0;
   int          vstart_cnt, ready_cnt, ven_cnt, req_cnt;
   int          first_vstart_cyc, first_req_cyc, ready_cyc, start_cyc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] quotient(input logic [63:0] a, input logic [63:0] b);
      return (b == 64'd0) ? '1 : a / b;
   endfunction

   task automatic monitor();
      exp_t e;
      if (mon_en) begin
         if (p_rst) begin
            check("reset_strobes", 64'({READY, DATA_IN_REQUEST, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE,
                                        VECTOR_START, VECTOR_DATA_A_IN_ENABLE, VECTOR_DATA_B_IN_ENABLE}), 64'd0);
            check("reset_data", DATA_OUT | VECTOR_SIZE_IN | VECTOR_DATA_A_IN | VECTOR_DATA_B_IN, 64'd0);
            exp_q.delete();
         end else begin
            check("vec_enables", 64'({VECTOR_DATA_A_IN_ENABLE, VECTOR_DATA_B_IN_ENABLE}), 64'({2{p_accept}}));
            if (p_accept) begin
               check("vec_a", VECTOR_DATA_A_IN, p_a);
               check("vec_b", VECTOR_DATA_B_IN, p_b);
            end
            check("out_j_enable", 64'(DATA_OUT_J_ENABLE), 64'(p_vout_en));
            if (p_vout_en) begin
               check("out_latency", DATA_OUT, p_vout);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_result: got %0h expected none (cycle %0d)", DATA_OUT, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("data_out", DATA_OUT, e.val);
                  check("out_i_enable", 64'(DATA_OUT_I_ENABLE), 64'(e.first));
               end
               obs_q.push_back(DATA_OUT);
               obs_first.push_back(DATA_OUT_I_ENABLE);
            end else begin
               check("out_i_idle", 64'(DATA_OUT_I_ENABLE), 64'd0);
            end
            if (VECTOR_START) check("vector_size", VECTOR_SIZE_IN, 64'(job_j));
         end
      end
      if (VECTOR_START) begin
         vstart_cnt++;
         if (first_vstart_cyc < 0) first_vstart_cyc = cyc;
      end
      if (DATA_IN_REQUEST) begin
         req_cnt++;
         if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (READY) begin
         ready_cnt++;
         if (ready_cyc < 0) ready_cyc = cyc;
      end
      if (VECTOR_DATA_A_IN_ENABLE) ven_cnt++;
      p_rst     = RST;
      p_accept  = DATA_IN_REQUEST & DATA_IN_ENABLE;
      p_a       = DATA_A_IN;
      p_b       = DATA_B_IN;
      p_vout_en = VECTOR_DATA_OUT_ENABLE;
      p_vout    = VECTOR_DATA_OUT;
   endtask

   // One clock: drive inputs 1 time unit after the edge, compare on the falling edge.
   task automatic cycle();
      logic go;
      @(posedge CLK);
      #1;
      cyc++;
      RST       = rst_req;
      START     = start_req;
      SIZE_I_IN = si_drv;
      SIZE_J_IN = sj_drv;

      // Divider stub: one quotient per accepted pair a cycle later, READY 2 cycles after the last
      VECTOR_DATA_OUT_ENABLE = 1'b0;
      VECTOR_READY           = force_vready;
      if (rst_req) begin
         stub_q.delete();
         stub_cnt = 0;
         stub_cd  = 0;
      end else begin
         if (stub_cd != 0) begin
            stub_cd--;
            if (stub_cd == 0) VECTOR_READY = 1'b1;
         end
         if (stub_q.size() > 0) begin
            VECTOR_DATA_OUT        = stub_q.pop_front();
            VECTOR_DATA_OUT_ENABLE = 1'b1;
            stub_cnt++;
            if (64'(stub_cnt) == stub_size) stub_cd = 2;
         end
         if (VECTOR_START) begin
            stub_size = VECTOR_SIZE_IN;
            stub_cnt  = 0;
         end
         if (VECTOR_DATA_A_IN_ENABLE && VECTOR_DATA_B_IN_ENABLE)
            stub_q.push_back(quotient(VECTOR_DATA_A_IN, VECTOR_DATA_B_IN));
      end

      // Producer
      go = (mode == 0) || (mode == 1 && (cyc % 2) == 0) || (mode == 2 && $urandom_range(0, 2) != 0);
      DATA_IN_ENABLE = 1'b0;
      DATA_A_IN      = {$urandom, $urandom};
      DATA_B_IN      = {$urandom, $urandom};
      if (DATA_IN_REQUEST) begin
         if (go && prod_idx < total) begin
            DATA_IN_ENABLE = 1'b1;
            DATA_A_IN      = a_mem[prod_idx];
            DATA_B_IN      = b_mem[prod_idx];
            exp_q.push_back('{val: quotient(a_mem[prod_idx], b_mem[prod_idx]),
                              first: ((prod_idx % job_j) == 0)});
            prod_idx++;
         end
      end else if (mode == 1) begin
         DATA_IN_ENABLE = go;
      end else if (junk_en) begin
         DATA_IN_ENABLE = 1'($urandom_range(0, 1));
      end

      @(negedge CLK);
      monitor();
   endtask

   task automatic clear_job_stats();
      exp_q.delete();
      obs_q.delete();
      obs_first.delete();
      vstart_cnt = 0; ready_cnt = 0; ven_cnt = 0; req_cnt = 0;
      first_vstart_cyc = -1; first_req_cyc = -1; ready_cyc = -1;
   endtask

   task automatic launch(input int i, input int j, input int m);
      clear_job_stats();
      job_j = j; total = i * j; prod_idx = 0; mode = m;
      si_drv = 64'(i); sj_drv = 64'(j);
      cycle();
      start_req = 1'b1;
      cycle();
      start_req = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic run_job(input int i, input int j, input int m, input bit mid_start);
      bit mid_done = 0;
      launch(i, j, m);
      for (int n = 0; n < 2000 && ready_cnt == 0; n++) begin
         if (mid_start && !mid_done && DATA_IN_REQUEST) begin
            start_req = 1'b1;
            si_drv    = 64'd1;
            sj_drv    = 64'd1;
            mid_done  = 1;
         end
         cycle();
         start_req = 1'b0;
      end
      repeat (6) cycle();
      check("ready_count", 64'(ready_cnt), 64'd1);
      check("vstart_count", 64'(vstart_cnt), 64'((i != 0 && j != 0) ? i : 0));
      check("vec_enable_count", 64'(ven_cnt), 64'(i * j));
      check("result_count", 64'(obs_q.size()), 64'(i * j));
      check("pending_results", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [63:0] t1_vals[6];
      bit          saw_req;
      bit          in_wait;

      t1_vals = '{64'd2, 64'd3, 64'd4, 64'd2, 64'd3, 64'd4};
      RST = 1'b1; START = 1'b0; SIZE_I_IN = '0; SIZE_J_IN = '0;
      DATA_IN_ENABLE = 1'b0; DATA_A_IN = '0; DATA_B_IN = '0;
      VECTOR_READY = 1'b0; VECTOR_DATA_OUT_ENABLE = 1'b0; VECTOR_DATA_OUT = '0;
      clear_job_stats();

      rst_req = 1'b1;
      cycle();
      mon_en = 1'b1;
      cycle();
      cycle();
      rst_req = 1'b0;
      cycle();

      // 2x3 matrix, enable held high
      a_mem[0:5] = '{64'd6, 64'd9, 64'd12, 64'd20, 64'd30, 64'd40};
      b_mem[0:5] = '{64'd3, 64'd3, 64'd3, 64'd10, 64'd10, 64'd10};
      run_job(2, 3, 0, 0);
      check("t1_vstart_cycle", 64'(first_vstart_cyc - start_cyc), 64'd1);
      check("t1_request_cycle", 64'(first_req_cyc - start_cyc), 64'd2);
      if (obs_q.size() == 6) begin
         for (int k = 0; k < 6; k++) check("t1_literal_out", obs_q[k], t1_vals[k]);
         check("t1_literal_i_flags",
               64'({obs_first[0], obs_first[1], obs_first[2], obs_first[3], obs_first[4], obs_first[5]}),
               64'b100100);
      end

      // 1x4, enable toggled every other cycle
      for (int k = 0; k < 4; k++) begin
         a_mem[k] = 64'($urandom_range(0, 100000));
         b_mem[k] = 64'($urandom_range(1, 50));
      end
      run_job(1, 4, 1, 0);

      // Zero row count
      run_job(0, 5, 0, 0);
      check("zero_ready_cycle", 64'(ready_cyc - start_cyc), 64'd1);
      check("zero_no_request", 64'(req_cnt), 64'd0);

      // 3x2 with a second START during FEED
      for (int k = 0; k < 6; k++) begin
         a_mem[k] = {$urandom, $urandom};
         b_mem[k] = 64'($urandom_range(0, 9));
      end
      run_job(3, 2, 0, 1);

      // Abort a 2x2 job in the WAIT of its second row
      for (int k = 0; k < 4; k++) begin
         a_mem[k] = 64'($urandom_range(0, 1000));
         b_mem[k] = 64'($urandom_range(1, 9));
      end
      launch(2, 2, 0);
      saw_req = 0;
      in_wait = 0;
      for (int n = 0; n < 500 && !in_wait; n++) begin
         cycle();
         if (vstart_cnt == 2 && DATA_IN_REQUEST) saw_req = 1;
         if (saw_req && !DATA_IN_REQUEST) in_wait = 1;
      end
      check("abort_reached_wait", 64'(in_wait), 64'd1);
      rst_req = 1'b1;
      cycle();
      rst_req = 1'b0;
      repeat (8) cycle();
      check("abort_no_ready", 64'(ready_cnt), 64'd0);
      a_mem[0] = 64'd8;
      b_mem[0] = 64'd2;
      run_job(1, 1, 0, 0);
      if (obs_q.size() == 1) check("after_abort_literal", obs_q[0], 64'd4);

      // Spurious VECTOR_READY and DATA_IN_ENABLE while idle
      clear_job_stats();
      force_vready = 1'b1;
      junk_en      = 1'b1;
      repeat (8) cycle();
      force_vready = 1'b0;
      junk_en      = 1'b0;
      cycle();
      check("idle_no_ready", 64'(ready_cnt), 64'd0);
      check("idle_no_vstart", 64'(vstart_cnt), 64'd0);
      check("idle_no_request", 64'(req_cnt), 64'd0);
      check("idle_no_forward", 64'(ven_cnt), 64'd0);
      check("idle_no_results", 64'(obs_q.size()), 64'd0);

      // Randomised jobs, including empty sizes and zero divisors
      for (int r = 0; r < 10; r++) begin
         int ri, rj;
         ri = $urandom_range(0, 3);
         rj = $urandom_range(0, 4);
         for (int k = 0; k < ri * rj; k++) begin
            a_mem[k] = {$urandom, $urandom};
            b_mem[k] = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom_range(1, 1000));
         end
         run_job(ri, rj, $urandom_range(0, 2), bit'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
